// File: rtl/mont_exp_ctrl.sv
// mont_exp_ctrl: left-to-right square-and-multiply sequencer driving one Montgomery multiplier
module mont_exp_ctrl #(
    parameter int WIDTH = 1024,
    parameter int EXP_W = 1024,
    parameter int LEN_W = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_r,
    input  logic [WIDTH-1:0] in_m,
    input  logic [EXP_W-1:0] in_e,
    input  logic [LEN_W-1:0] in_elen,
    output logic             mont_start,
    output logic [WIDTH-1:0] mont_a,
    output logic [WIDTH-1:0] mont_b,
    output logic [WIDTH-1:0] mont_m,
    input  logic [WIDTH-1:0] mont_result,
    input  logic             mont_done,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy
);
    localparam int IW = $clog2(EXP_W);

    typedef enum logic [2:0] {
        IDLE, SQ_REQ, SQ_WAIT, MUL_REQ, MUL_WAIT, FINAL_REQ, FINAL_WAIT, DONE
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] acc, acc_nxt, x, m;
    logic [EXP_W-1:0] e;
    logic [IW-1:0]    idx;
    logic [LEN_W-1:0] elen_c;
    logic             accept, in_wait, last, dec;

    assign accept  = state == IDLE && start;
    assign in_wait = state == SQ_WAIT || state == MUL_WAIT;
    assign elen_c  = in_elen > LEN_W'(EXP_W) ? LEN_W'(EXP_W) : in_elen;
    assign last    = idx == '0;
    assign acc_nxt = accept ? in_r : (in_wait && mont_done) ? mont_result : acc;
    assign dec     = in_wait && state_nxt == SQ_REQ;
    assign mont_m  = m;
    assign done    = state == DONE;
    assign busy    = state != IDLE;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       state_nxt = start ? (elen_c == '0 ? FINAL_REQ : SQ_REQ) : IDLE;
            SQ_REQ:     state_nxt = SQ_WAIT;
            SQ_WAIT:    state_nxt = !mont_done ? SQ_WAIT : e[idx] ? MUL_REQ : last ? FINAL_REQ : SQ_REQ;
            MUL_REQ:    state_nxt = MUL_WAIT;
            MUL_WAIT:   state_nxt = !mont_done ? MUL_WAIT : last ? FINAL_REQ : SQ_REQ;
            FINAL_REQ:  state_nxt = FINAL_WAIT;
            FINAL_WAIT: state_nxt = mont_done ? DONE : FINAL_WAIT;
            default:    state_nxt = IDLE;
        endcase
    end

    // Operands are loaded on entry to a REQ state so they are stable for the whole request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            acc        <= '0;
            x          <= '0;
            m          <= '0;
            e          <= '0;
            idx        <= '0;
            mont_start <= 1'b0;
            mont_a     <= '0;
            mont_b     <= '0;
            result     <= '0;
        end else begin
            state      <= state_nxt;
            acc        <= acc_nxt;
            mont_start <= state_nxt == SQ_REQ || state_nxt == MUL_REQ || state_nxt == FINAL_REQ;
            if (accept) begin
                x      <= in_x;
                m      <= in_m;
                e      <= in_e;
                idx    <= IW'(elen_c - 1'b1);
                result <= '0;
            end else if (dec) begin
                idx <= idx - 1'b1;
            end
            if (state == FINAL_WAIT && mont_done)
                result <= mont_result;
            if (state_nxt == SQ_REQ) begin
                mont_a <= acc_nxt;
                mont_b <= acc_nxt;
            end else if (state_nxt == MUL_REQ) begin
                mont_a <= acc_nxt;
                mont_b <= x;
            end else if (state_nxt == FINAL_REQ) begin
                mont_a <= acc_nxt;
                mont_b <= WIDTH'(1);
            end
        end
    end
endmodule

// File: tb/tb_mont_exp_ctrl.sv
// tb_mont_exp_ctrl: randomized scoreboard bench with a behavioural Montgomery multiplier and modexp reference
module tb_mont_exp_ctrl;
    localparam int W = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  in_x = '0, in_r = '0, in_m = '0, in_e = '0;
    logic [4:0]    in_elen = '0;
    logic          mont_start, done, busy;
    logic [W-1:0]  mont_a, mont_b, mont_m, result;
    logic [W-1:0]  mont_result = '0;
    logic          mont_done = 1'b0;

    int            total = 0, pass = 0, pulses = 0, n_done = 0;
    logic [W-1:0]  exp_q[$];
    int            exp_p[$];
    logic [W-1:0]  last_a = '0, last_b = '0;

    mont_exp_ctrl #(.WIDTH(W), .EXP_W(16), .LEN_W(5)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_x(in_x), .in_r(in_r), .in_m(in_m), .in_e(in_e), .in_elen(in_elen),
        .mont_start(mont_start), .mont_a(mont_a), .mont_b(mont_b), .mont_m(mont_m),
        .mont_result(mont_result), .mont_done(mont_done),
        .result(result), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act === req) pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    function automatic longint ref_pow(longint b, longint ex, int n, longint m);
        longint r = 1 % m;
        b = b % m;
        for (int i = 0; i < n; i++) begin
            if (ex[i]) r = r * b % m;
            b = b * b % m;
        end
        return r;
    endfunction

    // Behavioural multiplier: a*b*R^-1 mod M with random latency, aborts on reset.
    initial begin
        longint a, b, m, cm, rinv;
        int lat;
        cm = 0;
        rinv = 0;
        forever begin
            @(negedge clk);
            mont_done = 1'b0;
            if (!reset && mont_start) begin
                a = longint'(mont_a); b = longint'(mont_b); m = longint'(mont_m);
                last_a = mont_a; last_b = mont_b;
                if (m != cm) begin
                    cm = m;
                    for (longint k = 1; k < m; k++)
                        if ((k * 65536) % m == 1) begin rinv = k; break; end
                end
                lat = $urandom_range(1, 4);
                for (int i = 0; i < lat && !reset; i++) @(negedge clk);
                if (!reset) begin
                    chk("operand_hold", {16'h0, mont_a, mont_b, mont_m},
                        {16'h0, a[15:0], b[15:0], m[15:0]});
                    mont_result = W'(a * b % m * rinv % m);
                    mont_done = 1'b1;
                end
            end
        end
    end

    // Monitor: count requests and compare each completion against the scoreboard.
    always @(posedge clk) begin
        #1;
        if (reset) pulses = 0;
        else begin
            if (mont_start) pulses++;
            if (done) begin
                if (exp_q.size() == 0) chk("unexpected_done", 64'(done), 64'(0));
                else begin
                    chk("result", 64'(result), 64'(exp_q.pop_front()));
                    chk("mont_start_pulses", 64'(pulses), 64'(exp_p.pop_front()));
                end
                pulses = 0;
                n_done++;
            end
        end
    end

    task automatic run_op(input longint base, input longint m, input int ex, input int elen, input bit spurious);
        int eff, mask, d0, cyc;
        longint r;
        eff  = elen > 16 ? 16 : elen;
        mask = eff == 0 ? 0 : (1 << eff) - 1;
        r    = 65536 % m;
        exp_q.push_back(W'(ref_pow(base, longint'(ex & mask), eff, m)));
        exp_p.push_back(eff + $countones(16'(ex & mask)) + 1);
        d0 = n_done;
        @(negedge clk);
        start = 1'b1;
        in_x = W'((base % m) * r % m); in_r = W'(r); in_m = W'(m);
        in_e = W'(ex); in_elen = 5'(elen);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'(1));
        in_x = W'($urandom); in_r = W'($urandom); in_m = W'($urandom);
        in_e = W'($urandom); in_elen = 5'($urandom);
        cyc = 0;
        while (n_done == d0 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            start = spurious && busy && (cyc % 3 == 0);
        end
        start = 1'b0;
        if (n_done == d0) chk("done_timeout", 64'(0), 64'(1));
    endtask

    initial begin
        int cyc;
        longint m;
        #1;
        chk("rst_mont_start", 64'(mont_start), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_result", 64'(result), 64'(0));
        chk("rst_mont_abm", {16'h0, mont_a, mont_b, mont_m}, 64'(0));
        repeat (3) @(negedge clk);
        reset = 1'b0;

        run_op(2, 13, 5, 3, 0);
        run_op(2, 13, 12, 4, 0);
        run_op(2, 13, $urandom_range(0, 65535), 0, 0);
        chk("elen0_mont_a", 64'(last_a), 64'(3));
        chk("elen0_mont_b", 64'(last_b), 64'(1));
        run_op(2, 13, 16'hFFFF, 16, 1);

        @(negedge clk);
        start = 1'b1;
        in_x = 16'd6; in_r = 16'd3; in_m = 16'd13; in_e = 16'd5; in_elen = 5'd3;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (pulses < 3 && cyc < 200) begin @(negedge clk); cyc++; end
        chk("reach_second_square", 64'(pulses >= 3), 64'(1));
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_mont_start", 64'(mont_start), 64'(0));
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_result", 64'(result), 64'(0));
        repeat (3) @(negedge clk);
        chk("midrst_held_busy", 64'(busy), 64'(0));
        reset = 1'b0;
        run_op(2, 13, 5, 3, 0);

        run_op(2, 13, 16'hFFFF, 31, 0);
        for (int i = 0; i < 10; i++) begin
            m = longint'($urandom_range(1, 32767)) * 2 + 1;
            run_op(longint'($urandom_range(0, 65535)) % m, m, int'($urandom_range(0, 65535)),
                   int'($urandom_range(0, 20)), i[0]);
        end
        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
